// File: rtl/shift_add_mul.sv
// Sequential 8x8 shift-and-add multiplier: one load cycle, then eight enabled iterations.
// Define SHIFT_ADD_MUL_SIGNED_EN for two's-complement operands and product.
module shift_add_mul (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        enable,
   input  logic [7:0]  multiplicand,
   input  logic [7:0]  multiplier,
   output logic [15:0] product,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [8:0]  r_a;
   logic [7:0]  r_q;
   logic [7:0]  r_m;
   logic [2:0]  r_count;
   logic        r_done;

   logic        w_step;
   logic        w_last;
   logic [8:0]  w_mExt;
   logic [8:0]  w_sum;
   logic [8:0]  w_nextA;
   logic [7:0]  w_nextQ;

   assign w_step = (r_state == RUN) && enable && !start;
   assign w_last = (r_count == 3'd7);

`ifdef SHIFT_ADD_MUL_SIGNED_EN
   // The multiplier's sign bit carries negative weight, so the final step subtracts M.
   assign w_mExt = {r_m[7], r_m};

   always_comb begin
      w_sum = r_a;
      if (r_q[0]) begin
         if (w_last) begin
            w_sum = r_a - w_mExt;
         end else begin
            w_sum = r_a + w_mExt;
         end
      end
   end

   assign w_nextA = {w_sum[8], w_sum[8:1]};
`else
   assign w_mExt  = {1'b0, r_m};
   assign w_sum   = r_q[0] ? (r_a + w_mExt) : r_a;
   assign w_nextA = {1'b0, w_sum[8:1]};
`endif

   assign w_nextQ = {w_sum[0], r_q[7:1]};

   always_comb begin
      w_nextState = r_state;
      if (start) begin
         w_nextState = RUN;
      end else begin
         case (r_state)
            RUN:     if (enable && w_last) w_nextState = DONE;
            default: w_nextState = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Start wins over enable; done is only set on the eighth iteration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= 9'd0;
         r_q     <= 8'd0;
         r_m     <= 8'd0;
         r_count <= 3'd0;
         r_done  <= 1'b0;
      end else if (start) begin
         r_a     <= 9'd0;
         r_q     <= multiplier;
         r_m     <= multiplicand;
         r_count <= 3'd0;
         r_done  <= 1'b0;
      end else if (w_step) begin
         r_a     <= w_nextA;
         r_q     <= w_nextQ;
         r_count <= r_count + 3'd1;
         if (w_last) begin
            r_done <= 1'b1;
         end
      end
   end

   assign product = {r_a[7:0], r_q};
   assign done    = r_done;

endmodule

// File: doc/shift_add_mul.md
# shift_add_mul

Sequential 8×8 shift-and-add multiplier producing a 16-bit product in 8 enabled cycles. It is the inverse arithmetic unit to the restoring divider in the ALU datapath and shares the same start/enable/done control convention, so one controller sequences both. It is built from the existing D flip-flop, 2:1 mux, counter and ripple-carry adder primitives.

## Interface
- No parameters; operand width fixed at 8, product width 16.
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  load operands, clear accumulator and iteration counter
- enable  input  1  perform one multiply iteration on this edge
- multiplicand  input  8  operand M, sampled only on a start edge
- multiplier  input  8  operand Q, sampled only on a start edge
- product  output  16  {A[7:0], Q}; final result valid while done=1
- done  output  1  high after the 8th iteration; held until next start or reset

## Operation
- Registers: A (9 bits: carry plus A[7:0]), Q (8), M (8), 3-bit iteration count, done flag.
- States: IDLE (after reset, done=0), RUN (count 0..7), DONE (done=1).
- start=1 on an edge, in any state: A←0, Q←multiplier, M←multiplicand, count←0, done←0, state→RUN. start has priority over enable in the same cycle.
- RUN, enable=1, start=0: if Q[0]=1 then A←A+M (9-bit sum, carry kept), else A unchanged; then {A,Q} shifts right one bit, A[8] fills with 0 (unsigned). count increments; on the iteration with count=7, done←1 and state→DONE.
- RUN, enable=0: all registers hold (pause); there is no timeout.
- DONE: enable ignored; A, Q, done hold until start or rst.
- IDLE: enable ignored; product=0.
- product is {A[7:0],Q} at all times; mid-run values are partial and not meaningful.
- No overflow is possible: 255×255=65025 fits in 16 bits.

## Timing
- Reset (asynchronous, immediate on rst rising): product=16'h0000, done=0, state IDLE, count=0.
- rst asserted mid-run aborts the operation; no result is produced. Computation resumes only after a new start.
- start sampled at edge N; enable high at edges N+1..N+8 → done=1 and product valid immediately after edge N+8.
- Latency = 1 load cycle + 8 enabled cycles. Pause cycles (enable=0) add one cycle each.
- done rises exactly once per operation and stays high until the edge that samples start=1 (cleared on that same edge) or until reset.
- Operands may change freely after the start edge without affecting the result.

## Configuration
- SHIFT_ADD_MUL_SIGNED_EN defined: operands and product are two's complement.
  - A is sign-extended, M is treated as 9-bit sign-extended, and shifts are arithmetic (A[8] keeps its sign).
  - On the count=7 iteration, Q[0]=1 subtracts M (A←A−M) instead of adding.
  - Results: −128×−128 = 16'h4000; 127×−128 = 16'hC080.
- SHIFT_ADD_MUL_SIGNED_EN not defined: unsigned behaviour as described in Operation.
- The interface and timing are identical in both builds.

## Test plan
- Reset, then 13×11 with enable held high for 8 cycles → product=143 (16'h008F), done=1 one cycle after the 8th enable; product holds over 3 further enable cycles.
- 255×255 unsigned → 65025 (16'hFE01); 0×200 → 0 with done=1.
- 100×3 with enable dropped for 2 cycles after iteration 4 → product=300 (16'h012C), done asserts 2 cycles later than the unpaused case.
- Start 50×25, reassert start with 7×9 after 3 iterations → final product=63, no intermediate done pulse. Separately, rst pulse mid-run → product=0 and done=0 immediately; enable pulses afterwards leave product at 0.
- start and enable both high on one edge → treated as a load only; 8 further enables are still required before done=1.
- Build with SHIFT_ADD_MUL_SIGNED_EN: −3×5 → 16'hFFF1; −128×−128 → 16'h4000; 8'hFF×8'hFF → 16'h0001.
